memory_control: RTL and testbench



---
 rtl/memory_control.sv | 127 ++++++++++++
 tb/tb_memory_control.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/memory_control.sv
// Load/store controller between execute stage and data RAM: issues single-cycle stores and two-cycle loads.
// Optional build macro MEMCTL_ADDR_OFFSET_EN: load address becomes src1 + src2 instead of src1.
module memory_control #(
    parameter int unsigned DATA_W = 32,
    parameter logic [3:0]  OP_LDR = 4'b1001,
    parameter logic [3:0]  OP_STR = 4'b1010
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EN,
    input  logic [3:0]        OpCode,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [DATA_W-1:0] RAM_in,
    output logic              addr_sel,
    output logic              LDR_sel,
    output logic [DATA_W-1:0] Out_RAM,
    output logic [DATA_W-1:0] Out_reg,
    output logic              RW_out,
    output logic [DATA_W-1:0] Out_addr,
    output logic              busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        LD_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_addr_sel;
    logic                r_ldr_sel;
    logic [DATA_W-1:0]   r_out_ram;
    logic [DATA_W-1:0]   r_out_reg;
    logic                r_rw;
    logic [DATA_W-1:0]   r_out_addr;
    logic                r_busy;

    logic                w_addr_sel;
    logic                w_ldr_sel;
    logic [DATA_W-1:0]   w_out_ram;
    logic [DATA_W-1:0]   w_out_reg;
    logic                w_rw;
    logic [DATA_W-1:0]   w_out_addr;
    logic                w_busy;
    logic [DATA_W-1:0]   w_ld_addr;
    logic                w_is_ldr;
    logic                w_is_str;

`ifdef MEMCTL_ADDR_OFFSET_EN
    assign w_ld_addr = src1 + src2;
`else
    assign w_ld_addr = src1;
`endif

    assign w_is_ldr = EN && (OpCode == OP_LDR);
    assign w_is_str = EN && (OpCode == OP_STR);

    // Next-state and next-output decode; address and load data hold unless updated.
    always_comb begin
        w_next_state = r_state;
        w_addr_sel   = 1'b0;
        w_ldr_sel    = 1'b0;
        w_out_ram    = '0;
        w_out_reg    = r_out_reg;
        w_rw         = 1'b1;
        w_out_addr   = r_out_addr;
        w_busy       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_is_ldr) begin
                    w_out_addr   = w_ld_addr;
                    w_addr_sel   = 1'b1;
                    w_busy       = 1'b1;
                    w_next_state = LD_WAIT;
                end else if (w_is_str) begin
                    w_out_addr   = src1;
                    w_out_ram    = src2;
                    w_rw         = 1'b0;
                    w_addr_sel   = 1'b1;
                end
            end
            LD_WAIT: begin
                // RAM answers one cycle after the address; opcode is not looked at here.
                w_out_reg    = RAM_in;
                w_ldr_sel    = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr_sel <= 1'b0;
            r_ldr_sel  <= 1'b0;
            r_out_ram  <= '0;
            r_out_reg  <= '0;
            r_rw       <= 1'b1;
            r_out_addr <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_addr_sel <= w_addr_sel;
            r_ldr_sel  <= w_ldr_sel;
            r_out_ram  <= w_out_ram;
            r_out_reg  <= w_out_reg;
            r_rw       <= w_rw;
            r_out_addr <= w_out_addr;
            r_busy     <= w_busy;
        end
    end

    assign addr_sel = r_addr_sel;
    assign LDR_sel  = r_ldr_sel;
    assign Out_RAM  = r_out_ram;
    assign Out_reg  = r_out_reg;
    assign RW_out   = r_rw;
    assign Out_addr = r_out_addr;
    assign busy     = r_busy;

endmodule

// File: tb/tb_memory_control.sv
// Scoreboard bench for memory_control: expected outputs are queued as each cycle's stimulus is driven.
module tb_memory_control;

    localparam int DW = 32;
    localparam logic [3:0] LDR = 4'b1001;
    localparam logic [3:0] STR = 4'b1010;

    logic          clk;
    logic          rst_n;
    logic          EN;
    logic [3:0]    OpCode;
    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
    logic [DW-1:0] RAM_in;
    logic          addr_sel;
    logic          LDR_sel;
    logic [DW-1:0] Out_RAM;
    logic [DW-1:0] Out_reg;
    logic          RW_out;
    logic [DW-1:0] Out_addr;
    logic          busy;

    typedef struct {
        logic          addr_sel;
        logic          ldr_sel;
        logic [DW-1:0] out_ram;
        logic [DW-1:0] out_reg;
        logic          rw;
        logic [DW-1:0] out_addr;
        logic          busy;
    } exp_t;

    exp_t          sb_q[$];
    int            n_vec;
    int            n_miscmp;
    logic          m_ld;
    logic [DW-1:0] m_addr;
    logic [DW-1:0] m_reg;

    memory_control #(.DATA_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .EN       (EN),
        .OpCode   (OpCode),
        .src1     (src1),
        .src2     (src2),
        .RAM_in   (RAM_in),
        .addr_sel (addr_sel),
        .LDR_sel  (LDR_sel),
        .Out_RAM  (Out_RAM),
        .Out_reg  (Out_reg),
        .RW_out   (RW_out),
        .Out_addr (Out_addr),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".addr_sel"}, 32'(addr_sel), 32'd0);
        chk({tag, ".LDR_sel"},  32'(LDR_sel),  32'd0);
        chk({tag, ".Out_RAM"},  Out_RAM,       32'd0);
        chk({tag, ".Out_reg"},  Out_reg,       32'd0);
        chk({tag, ".RW_out"},   32'(RW_out),   32'd1);
        chk({tag, ".Out_addr"}, Out_addr,      32'd0);
        chk({tag, ".busy"},     32'(busy),     32'd0);
    endtask

    // Drive one cycle of stimulus, queue what the controller should show after the edge, then compare.
    task automatic step(input string tag, input logic en, input logic [3:0] op,
                        input logic [DW-1:0] s1, input logic [DW-1:0] s2, input logic [DW-1:0] ram);
        exp_t e;
        exp_t got;
        @(negedge clk);
        EN = en; OpCode = op; src1 = s1; src2 = s2; RAM_in = ram;
        e.addr_sel = 1'b0; e.ldr_sel = 1'b0; e.out_ram = '0; e.rw = 1'b1; e.busy = 1'b0;
        if (m_ld) begin
            m_reg     = ram;
            e.ldr_sel = 1'b1;
            m_ld      = 1'b0;
        end else if (en && op == LDR) begin
`ifdef MEMCTL_ADDR_OFFSET_EN
            m_addr = s1 + s2;
`else
            m_addr = s1;
`endif
            e.addr_sel = 1'b1;
            e.busy     = 1'b1;
            m_ld       = 1'b1;
        end else if (en && op == STR) begin
            m_addr     = s1;
            e.out_ram  = s2;
            e.rw       = 1'b0;
            e.addr_sel = 1'b1;
        end
        e.out_addr = m_addr;
        e.out_reg  = m_reg;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_miscmp++;
            $display("FAIL %s: scoreboard empty, got no expectation", tag);
        end else begin
            got = sb_q.pop_front();
            chk({tag, ".addr_sel"}, 32'(addr_sel), 32'(got.addr_sel));
            chk({tag, ".LDR_sel"},  32'(LDR_sel),  32'(got.ldr_sel));
            chk({tag, ".Out_RAM"},  Out_RAM,       got.out_ram);
            chk({tag, ".Out_reg"},  Out_reg,       got.out_reg);
            chk({tag, ".RW_out"},   32'(RW_out),   32'(got.rw));
            chk({tag, ".Out_addr"}, Out_addr,      got.out_addr);
            chk({tag, ".busy"},     32'(busy),     32'(got.busy));
        end
    endtask

    initial begin
        n_vec = 0; n_miscmp = 0;
        m_ld = 1'b0; m_addr = '0; m_reg = '0;
        rst_n = 1'b0; EN = 1'b0; OpCode = 4'b0000; src1 = '0; src2 = '0; RAM_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Disabled stage ignores the load opcode.
        for (int i = 0; i < 4; i++) step("en0", 1'b0, LDR, 32'h11, 32'h1F, 32'hDEAD_BEEF);

        // Store, then an unrelated opcode.
        step("str",   1'b1, STR,     32'h0000_1111, 32'h00FF_00FF, 32'h0);
        step("nop",   1'b1, 4'b0010, 32'h0000_1111, 32'h00FF_00FF, 32'h0);

        // Load: address, then data with LDR_sel pulse, then hold.
        step("ld1",   1'b1, LDR,     32'h2323_1111, 32'h1234_5678, 32'hCAFE_F00D);
        step("ld2",   1'b1, LDR,     32'h2323_1111, 32'h1234_5678, 32'hCAFE_F00D);
        step("ld3",   1'b0, LDR,     32'h2323_1111, 32'h1234_5678, 32'h5555_AAAA);

        // Offset wrap case for the load address.
        step("ldw1",  1'b1, LDR,     32'hFFFF_FFF0, 32'h0000_0020, 32'h0);
        step("ldw2",  1'b0, 4'b0000, 32'h0,         32'h0,         32'h0BAD_F00D);

        // Load followed by a store held on the inputs.
        step("ls1",   1'b1, LDR,     32'h0000_0100, 32'h0000_0004, 32'h0);
        step("ls2",   1'b1, STR,     32'h0000_0200, 32'hA5A5_A5A5, 32'h1357_9BDF);
        step("ls3",   1'b1, STR,     32'h0000_0200, 32'hA5A5_A5A5, 32'h0);

        // Back-to-back stores.
        for (int i = 1; i <= 3; i++) step("b2b", 1'b1, STR, 32'h0000_0300 + i, i, 32'h0);
        step("idle",  1'b0, STR,     32'h0,         32'h0,         32'h0);

        // Asynchronous reset in the middle of a load.
        step("rl1",   1'b1, LDR,     32'h0000_0400, 32'h0,         32'hFEED_FACE);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("arst");
        m_ld = 1'b0; m_addr = '0; m_reg = '0;
        @(negedge clk);
        rst_n = 1'b1;
        EN = 1'b0;
        step("rl2",   1'b0, 4'b0000, 32'h0,         32'h0,         32'hFEED_FACE);
        step("rl3",   1'b0, 4'b0000, 32'h0,         32'h0,         32'hFEED_FACE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
